// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches 16-bit words over a req/ack handshake into a small prefetch FIFO.
// Optional perf counters (fetch_count, stall_count) are built only when FETCH_PERF_EN is defined.
module instr_fetch_unit #(
    parameter int                  PC_WIDTH   = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter int                  FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [15:0]         imem_rdata,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                stall,
    output logic                instr_valid,
    output logic [15:0]         instruction,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic [15:0]         fetch_count,
    output logic [15:0]         stall_count
);

    localparam int        AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t              state, next_state;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] drain_addr;
    logic [15:0]         fifo_word [FIFO_DEPTH];
    logic [PC_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr, count, next_count;
    logic                accept, push, pop;

    assign count       = wr_ptr - rd_ptr;
    assign instr_valid = (count != '0);
    assign accept      = (state == REQ) && imem_ack;
    // A redirect kills both the returning word and any pop in the same cycle.
    assign push        = accept && !branch_taken;
    assign pop         = instr_valid && !stall && !branch_taken;
    assign next_count  = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    assign instruction = instr_valid ? fifo_word[rd_ptr[AW-1:0]] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr[AW-1:0]]   : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (branch_taken || count < DEPTH_CNT) next_state = REQ;
            end
            REQ: begin
                if (branch_taken) begin
                    next_state = imem_ack ? REQ : DRAIN;
                end else if (imem_ack) begin
                    next_state = (next_count < DEPTH_CNT) ? REQ : IDLE;
                end
            end
            DRAIN: begin
                if (imem_ack) next_state = REQ;
            end
            default: next_state = IDLE;
        endcase
    end

    // The abandoned address stays on the bus while draining, independent of the new fetch_pc.
    always_comb begin
        imem_req  = (state == REQ) || (state == DRAIN);
        imem_addr = (state == DRAIN) ? drain_addr : fetch_pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            drain_addr <= '0;
        end else begin
            if (state == REQ && branch_taken && !imem_ack) drain_addr <= fetch_pc;
            if (branch_taken) begin
                fetch_pc <= branch_target;
            end else if (accept) begin
                fetch_pc <= fetch_pc + PC_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (branch_taken) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word[wr_ptr[AW-1:0]] <= imem_rdata;
            fifo_pc[wr_ptr[AW-1:0]]   <= fetch_pc;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (pop && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
            if (instr_valid && stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
        end
    end
`else
    assign fetch_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; a second instance checks PC wrap from RESET_PC=FFFE.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [15:0] imem_addr, imem_rdata;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        stall;
    logic        instr_valid;
    logic [15:0] instruction, instr_pc, fetch_count, stall_count;

    logic        req2, ack2, valid2;
    logic [15:0] addr2, rdata2, instr2, pc2, fcount2, scount2;

    int tests_run    = 0;
    int tests_failed = 0;
    int latency      = 0;
    int wait_cnt;
    int pops, stalls, got, cyc;
    logic s;
    logic [15:0] exp_pc2;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
        .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
        .fetch_count(fetch_count), .stall_count(stall_count)
    );

    instr_fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
        .instr_valid(valid2), .instruction(instr2), .instr_pc(pc2),
        .fetch_count(fcount2), .stall_count(scount2)
    );

    // Memory model: acks after 'latency' waiting cycles, returns addr ^ A000.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wait_cnt <= 0;
        else if (!imem_req || imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    always_comb begin
        imem_ack   = imem_req && (wait_cnt >= latency);
        imem_rdata = imem_addr ^ 16'hA000;
    end

    assign ack2   = req2;
    assign rdata2 = addr2 ^ 16'hA000;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic br, input logic [15:0] tgt);
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        tick();
    endtask

    task automatic doReset(input int lat);
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        latency       = lat;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Test 1: reset state and sustained 0-wait fetch
        doReset(0);
        checkOutput("rst_req", imem_req, 0);
        checkOutput("rst_valid", instr_valid, 0);
        checkOutput("rst_instr", instruction, 0);
        checkOutput("rst_pc", instr_pc, 0);
        checkOutput("rst_fcount", fetch_count, 0);
        checkOutput("rst_scount", stall_count, 0);
        applyStimulus(0, 0, 0);
        checkOutput("t1_req_rise", imem_req, 1);
        checkOutput("t1_addr0", imem_addr, 0);
        checkOutput("t1_valid_c1", instr_valid, 0);
        applyStimulus(0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            exp_pc2 = 16'hFFFE + 16'(k);
            checkOutput("t1_valid", instr_valid, 1);
            checkOutput("t1_pc", instr_pc, k);
            checkOutput("t1_instr", instruction, k ^ 16'hA000);
            checkOutput("t5_wrap_pc", pc2, exp_pc2);
            applyStimulus(0, 0, 0);
        end

        // Test 2: stall fills FIFO, then in-order release
        doReset(0);
        for (int k = 0; k < 5; k++) applyStimulus(1, 0, 0);
        checkOutput("t2_valid", instr_valid, 1);
        checkOutput("t2_req_full", imem_req, 0);
        checkOutput("t2_head_pc", instr_pc, 0);
        checkOutput("t2_head_instr", instruction, 16'hA000);
        got = 0;
        for (int c = 0; c < 12 && got < 3; c++) begin
            if (instr_valid) begin
                checkOutput("t2_order", instr_pc, got);
                got++;
            end
            applyStimulus(0, 0, 0);
        end
        checkOutput("t2_delivered", got, 3);

        // Test 3: reset mid-request, then redirect while waiting on a slow memory
        doReset(3);
        applyStimulus(0, 0, 0);
        checkOutput("t3_req_pre", imem_req, 1);
        reset = 1'b1;
        #1;
        checkOutput("t3_req_abandon", imem_req, 0);
        doReset(3);
        cyc = 0;
        while (!(imem_req && imem_addr == 16'd5) && cyc < 100) begin
            applyStimulus(0, 0, 0);
            cyc++;
        end
        checkOutput("t3_found_pc5", cyc < 100, 1);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 16'h0040);
        checkOutput("t3_drain_addr", imem_addr, 5);
        checkOutput("t3_drain_req", imem_req, 1);
        checkOutput("t3_flush_valid", instr_valid, 0);
        applyStimulus(0, 0, 0);
        checkOutput("t3_hold_addr", imem_addr, 5);
        applyStimulus(0, 0, 0);
        checkOutput("t3_new_addr", imem_addr, 16'h0040);
        checkOutput("t3_discard", instr_valid, 0);
        cyc = 0;
        while (!instr_valid && cyc < 10) begin
            applyStimulus(0, 0, 0);
            cyc++;
        end
        checkOutput("t3_target_pc", instr_pc, 16'h0040);
        checkOutput("t3_target_instr", instruction, 16'hA040);

        // Test 4: redirect coinciding with ack and pop
        doReset(0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0);
        checkOutput("t4_pre_ack", imem_ack, 1);
        checkOutput("t4_pre_valid", instr_valid, 1);
        applyStimulus(0, 1, 16'h0123);
        checkOutput("t4_flush", instr_valid, 0);
        checkOutput("t4_addr", imem_addr, 16'h0123);
        applyStimulus(0, 0, 0);
        checkOutput("t4_valid", instr_valid, 1);
        checkOutput("t4_pc", instr_pc, 16'h0123);
        checkOutput("t4_instr", instruction, 16'hA123);

        // Test 6: 10 pops and 4 stall cycles, then freeze with a held redirect
        doReset(0);
        pops   = 0;
        stalls = 0;
        for (int c = 0; c < 60 && pops < 10; c++) begin
            s = (pops == 3) && (stalls < 4) && instr_valid;
            if (instr_valid && s)  stalls++;
            if (instr_valid && !s) pops++;
            applyStimulus(s, 0, 0);
        end
        checkOutput("t6_pops_reached", pops, 10);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0);
`ifdef FETCH_PERF_EN
        checkOutput("t6_fetch_count", fetch_count, 10);
        checkOutput("t6_stall_count", stall_count, 4);
`else
        checkOutput("t6_fetch_count", fetch_count, 0);
        checkOutput("t6_stall_count", stall_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
